sequence_match_engine: RTL and testbench

Downstream consumer of the stored 10-bit target pattern produced by the input-capture stage (its `sequence` output).
Accepts a serial bit stream, one bit per `bit_valid` cycle, into a sliding window. Flags every occurrence of the stored pattern in the stream; overlapping occurrences are detected.
Keeps a saturating match count and restarts its window whenever the stored pattern changes.

---
 rtl/sequence_match_engine.sv | 111 +++++++++++
 tb/tb_sequence_match_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_match_engine.sv
// Serial pattern matcher. Shifts accepted bits into a sliding window, flags every
// (overlapping) occurrence of the stored pattern and keeps a saturating match count.
module sequence_match_engine #(
    parameter int SEQ_LEN = 10,
    parameter int CNT_W   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SEQ_LEN-1:0] seq_pattern,
    input  logic               bit_in,
    input  logic               bit_valid,
    input  logic               clear,
    output logic [SEQ_LEN-1:0] window,
    output logic               filled,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count,
    output logic [1:0]         state_dbg
);

    // Handshake: bit_valid is a valid-only strobe with no backpressure; bit_in is
    // consumed on every rising edge where bit_valid is high, and ignored otherwise.

    localparam int FW = $clog2(SEQ_LEN + 1);
    localparam logic [FW-1:0] LAST_FILL = FW'(SEQ_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    state_t             state;
    logic [FW-1:0]      fill_cnt;
    logic [SEQ_LEN-1:0] pattern_q;
    logic [SEQ_LEN-1:0] win_next;
    logic               compare_en;
    logic               hit;

    assign win_next = (window << 1) | SEQ_LEN'(bit_in);

    // The bit that completes the window is compared in the same cycle it arrives.
    assign compare_en = (state == ARMED) ||
                        (state == FILL && fill_cnt == LAST_FILL) ||
                        (state == IDLE && SEQ_LEN == 1);
    assign hit        = compare_en && (win_next == pattern_q);
    assign state_dbg  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q   <= seq_pattern;
            window      <= '0;
            fill_cnt    <= '0;
            state       <= IDLE;
            filled      <= 1'b0;
            detected    <= 1'b0;
            match_count <= '0;
        end else if (seq_pattern != pattern_q) begin
            // New target: restart the window but keep the running count.
            pattern_q <= seq_pattern;
            window    <= '0;
            fill_cnt  <= '0;
            state     <= IDLE;
            filled    <= 1'b0;
            detected  <= 1'b0;
        end else if (clear) begin
            window      <= '0;
            fill_cnt    <= '0;
            state       <= IDLE;
            filled      <= 1'b0;
            detected    <= 1'b0;
            match_count <= '0;
        end else begin
            detected <= 1'b0;
            if (bit_valid) begin
                window <= win_next;
                case (state)
                    IDLE: begin
                        fill_cnt <= FW'(1);
                        if (SEQ_LEN == 1) begin
                            state  <= ARMED;
                            filled <= 1'b1;
                        end else begin
                            state <= FILL;
                        end
                    end
                    FILL: begin
                        fill_cnt <= fill_cnt + FW'(1);
                        if (fill_cnt == LAST_FILL) begin
                            state  <= ARMED;
                            filled <= 1'b1;
                        end
                    end
                    ARMED: begin
                        state <= ARMED;
                    end
                    default: begin
                        state  <= IDLE;
                        filled <= 1'b0;
                    end
                endcase
                if (hit) begin
                    detected <= 1'b1;
                    if (match_count != {CNT_W{1'b1}}) begin
                        match_count <= match_count + CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sequence_match_engine.sv
// Bench for sequence_match_engine: directed table, multi-cycle corner sequences and
// randomized traffic, all checked against a bit-history model of the matcher.
module tb_sequence_match_engine;

    localparam int SEQ_LEN = 10;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam logic [SEQ_LEN-1:0] P1 = 10'b1011101101;
    localparam logic [SEQ_LEN-1:0] P2 = 10'b1010101010;
    localparam logic [SEQ_LEN-1:0] P3 = 10'b0110101100;
    localparam logic [SEQ_LEN-1:0] P0 = 10'b0000000000;

    logic               clk = 1'b0;
    logic               rst;
    logic [SEQ_LEN-1:0] seq_pattern;
    logic               bit_in;
    logic               bit_valid;
    logic               clear;
    logic [SEQ_LEN-1:0] window;
    logic               filled;
    logic               detected;
    logic [CNT_W-1:0]   match_count;
    logic [1:0]         state_dbg;

    sequence_match_engine #(.SEQ_LEN(SEQ_LEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .seq_pattern (seq_pattern),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .clear       (clear),
        .window      (window),
        .filled      (filled),
        .detected    (detected),
        .match_count (match_count),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int n_vec  = 0;
    int n_err  = 0;
    int pulses = 0;

    // ---------------- reference model ----------------
    // The model remembers the accepted bits since the last restart; the window is
    // simply the newest SEQ_LEN of them read as a binary number.
    bit               hist[$];
    logic [SEQ_LEN-1:0] m_pat;
    int               m_cnt = 0;
    logic             m_det = 1'b0;
    logic [CNT_W-1:0] exp_q[$];

    function automatic logic [SEQ_LEN-1:0] m_window();
        logic [SEQ_LEN-1:0] w = '0;
        int n = hist.size();
        for (int i = 0; i < n; i++) begin
            if (hist[i]) w = w + (SEQ_LEN'(1) << (n - 1 - i));
        end
        return w;
    endfunction

    task automatic model_edge(input logic r, input logic c, input logic v,
                              input logic b, input logic [SEQ_LEN-1:0] s);
        m_det = 1'b0;
        if (r) begin
            hist.delete();
            m_pat = s;
            m_cnt = 0;
        end else if (s != m_pat) begin
            hist.delete();
            m_pat = s;
        end else if (c) begin
            hist.delete();
            m_cnt = 0;
        end else if (v) begin
            hist.push_back(b);
            if (hist.size() > SEQ_LEN) void'(hist.pop_front());
            if (hist.size() == SEQ_LEN && m_window() == m_pat) begin
                m_det = 1'b1;
                if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Inputs change on the falling edge; outputs are checked on the next falling edge.
    task automatic step(input logic r, input logic c, input logic v,
                        input logic b, input logic [SEQ_LEN-1:0] s);
        logic [CNT_W-1:0] exp_cnt;
        rst = r; clear = c; bit_valid = v; bit_in = b; seq_pattern = s;
        @(posedge clk);
        model_edge(r, c, v, b, s);
        exp_q.push_back(CNT_W'(m_cnt));
        @(negedge clk);
        exp_cnt = exp_q.pop_front();
        check("window", 32'(window), 32'(m_window()));
        check("filled", 32'(filled), 32'(hist.size() == SEQ_LEN));
        check("detected", 32'(detected), 32'(m_det));
        check("match_count", 32'(match_count), 32'(exp_cnt));
        if (detected === 1'b1) pulses++;
    endtask

    task automatic feed(input logic [SEQ_LEN-1:0] s, input logic [SEQ_LEN-1:0] bits,
                        input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'b1, bits[SEQ_LEN-1-i], s);
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0, s);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic               r;
        logic               v;
        logic               b;
        logic [SEQ_LEN-1:0] exp_win;
        logic               exp_filled;
        logic               exp_det;
        logic [CNT_W-1:0]   exp_cnt;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [SEQ_LEN-1:0] pats[4];
        logic [SEQ_LEN-1:0] cur;
        logic bias;

        rst = 1'b1; clear = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; seq_pattern = P1;
        @(negedge clk);

        // Test 1 as a table: reset, the ten pattern bits, then an idle cycle.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 10'd0,   1'b0, 1'b0, 4'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 10'd1,   1'b0, 1'b0, 4'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 10'd2,   1'b0, 1'b0, 4'd0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 10'd5,   1'b0, 1'b0, 4'd0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 10'd11,  1'b0, 1'b0, 4'd0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 10'd23,  1'b0, 1'b0, 4'd0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 10'd46,  1'b0, 1'b0, 4'd0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 10'd93,  1'b0, 1'b0, 4'd0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 10'd187, 1'b0, 1'b0, 4'd0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 10'd374, 1'b0, 1'b0, 4'd0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 10'd749, 1'b1, 1'b1, 4'd1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 10'd749, 1'b1, 1'b0, 4'd1};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 10'd749, 1'b1, 1'b0, 4'd1};
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].r, 1'b0, tbl[i].v, tbl[i].b, P1);
            check("t1_window", 32'(window), 32'(tbl[i].exp_win));
            check("t1_filled", 32'(filled), 32'(tbl[i].exp_filled));
            check("t1_detected", 32'(detected), 32'(tbl[i].exp_det));
            check("t1_count", 32'(match_count), 32'(tbl[i].exp_cnt));
        end

        // Test 2: overlapping matches on an alternating pattern.
        step(1'b1, 1'b0, 1'b0, 1'b0, P2);
        pulses = 0;
        feed(P2, P2, SEQ_LEN, 0);
        feed(P2, 10'b1000000000, 1, 0);
        check("t2_no_pulse_bit11", 32'(detected), 32'd0);
        feed(P2, 10'b0000000000, 1, 0);
        check("t2_pulse_bit12", 32'(detected), 32'd1);
        check("t2_pulses", 32'(pulses), 32'd2);
        check("t2_count", 32'(match_count), 32'd2);

        // Test 3: pattern change discards the coincident bit and keeps the count.
        step(1'b1, 1'b0, 1'b0, 1'b0, P1);
        feed(P1, P1, SEQ_LEN, 0);
        step(1'b0, 1'b0, 1'b1, 1'b1, P3);
        check("t3_filled", 32'(filled), 32'd0);
        check("t3_window", 32'(window), 32'd0);
        check("t3_count_held", 32'(match_count), 32'd1);
        feed(P3, P3, SEQ_LEN, 0);
        check("t3_detected", 32'(detected), 32'd1);
        check("t3_count", 32'(match_count), 32'd2);

        // Test 4: gapped input.
        step(1'b1, 1'b0, 1'b0, 1'b0, P1);
        pulses = 0;
        feed(P1, P1, SEQ_LEN, 3);
        check("t4_pulses", 32'(pulses), 32'd1);
        check("t4_window", 32'(window), 32'(P1));

        // Test 5: saturation, then clear.
        step(1'b1, 1'b0, 1'b0, 1'b0, P0);
        pulses = 0;
        for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 1'b1, 1'b0, P0);
        check("t5_pulses", 32'(pulses), 32'd21);
        check("t5_count_sat", 32'(match_count), 32'(CNT_MAX));
        step(1'b0, 1'b1, 1'b1, 1'b0, P0);
        check("t5_clear_count", 32'(match_count), 32'd0);
        check("t5_clear_filled", 32'(filled), 32'd0);

        // Test 6: reset mid-stream discards the partial window.
        step(1'b1, 1'b0, 1'b0, 1'b0, P1);
        feed(P1, P1, 6, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, P1);
        pulses = 0;
        feed(P1, P1, SEQ_LEN - 1, 0);
        check("t6_no_early", 32'(pulses), 32'd0);
        feed(P1, 10'b1000000000, 1, 0);
        check("t6_pulses", 32'(pulses), 32'd1);
        check("t6_count", 32'(match_count), 32'd1);

        // Randomized traffic over a few patterns, with biased bits so matches occur.
        pats[0] = 10'h3FF; pats[1] = 10'h000; pats[2] = P2; pats[3] = 10'b1100110011;
        cur = pats[0];
        step(1'b1, 1'b0, 1'b0, 1'b0, cur);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) cur = pats[$urandom_range(0, 3)];
            if (cur == 10'h3FF) bias = 1'b1;
            else if (cur == 10'h000) bias = 1'b0;
            else bias = 1'($urandom_range(0, 1));
            step(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) != 0) ? bias : ~bias, cur);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
